zigbee_chip_demod: RTL and testbench

Differential-phase chip demodulator for the ZigBee O-QPSK/MSK receive path. It consumes the quantized phase stream produced by the CORDIC phase extractor. It computes the wrapped sample-to-sample phase difference and integrates it over one chip period. It slices the sign into a hard chip and packs chips into 32-chip words for the downstream symbol correlator.

---
 rtl/zigbee_chip_demod.sv | 154 +++++++++++++++
 tb/tb_zigbee_chip_demod.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zigbee_chip_demod.sv
// ---------------------------------------------------------------------------
// zigbee_chip_demod
//
// Differential-phase chip demodulator for the ZigBee O-QPSK/MSK receive path.
// Takes the quantized phase stream from the CORDIC phase extractor and forms
// the wrapped sample-to-sample phase difference. It integrates that
// difference over one chip period and slices the sign into a hard chip.
// Chips are packed MSB-first into words for the downstream symbol correlator.
//
// Parameters
//   W_SIZE          phase word width; the full circle is 2^W_SIZE codes
//   SPC             phase differences per chip (power of 2, >= 2)
//   CHIPS_PER_WORD  chips packed into each output word
//
// Ports
//   Clk        in   single clock, rising edge
//   Rst        in   synchronous active-high reset
//   Win        in   signed phase sample
//   WinValid   in   Win carries a new sample this cycle
//   Sync       in   one-cycle pulse restarting chip and word alignment
//   Chip       out  hard chip decision, valid with ChipValid
//   ChipValid  out  one-cycle pulse per chip
//   ChipWord   out  packed chips, first received chip in the MSB
//   WordValid  out  one-cycle pulse when ChipWord holds a complete word
// ---------------------------------------------------------------------------
module zigbee_chip_demod #(
    parameter int W_SIZE         = 6,
    parameter int SPC            = 4,
    parameter int CHIPS_PER_WORD = 32
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic signed [W_SIZE-1:0]    Win,
    input  logic                        WinValid,
    input  logic                        Sync,
    output logic                        Chip,
    output logic                        ChipValid,
    output logic [CHIPS_PER_WORD-1:0]   ChipWord,
    output logic                        WordValid
);

    // The accumulator holds at most SPC sign-extended differences, so
    // log2(SPC) guard bits are enough to rule out overflow.
    localparam int ACC_SIZE = W_SIZE + $clog2(SPC);
    localparam int SCNT_W   = $clog2(SPC);
    localparam int CCNT_W   = $clog2(CHIPS_PER_WORD);

    localparam logic [SCNT_W-1:0] SAMPLE_LAST = SCNT_W'(SPC - 1);
    localparam logic [CCNT_W-1:0] CHIP_LAST   = CCNT_W'(CHIPS_PER_WORD - 1);

    typedef enum logic {
        WAIT_FIRST,
        ACCUM
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [W_SIZE-1:0]   w_prev;
    logic signed [ACC_SIZE-1:0] acc;
    logic [SCNT_W-1:0]          sample_cnt;
    logic [CCNT_W-1:0]          chip_cnt;

    logic signed [W_SIZE-1:0]   d_w;
    logic signed [ACC_SIZE-1:0] d_w_ext;
    logic signed [ACC_SIZE-1:0] chip_sum;
    logic                       chip_bit;
    logic                       sample_last;
    logic                       word_last;
    logic                       take_diff;

    // Phase difference at the native width: the subtraction wraps modulo
    // the full circle, which is exactly the shortest-arc phase step.
    always_comb begin
        d_w         = Win - w_prev;
        d_w_ext     = {{(ACC_SIZE - W_SIZE){d_w[W_SIZE-1]}}, d_w};
        chip_sum    = acc + d_w_ext;
        // Strictly positive sum gives chip 1; a zero sum slices to 0.
        chip_bit    = !chip_sum[ACC_SIZE-1] && (chip_sum != '0);
        sample_last = (sample_cnt == SAMPLE_LAST);
        word_last   = (chip_cnt == CHIP_LAST);
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= WAIT_FIRST;
        end else begin
            state <= state_next;
        end
    end

    // Next state. Sync overrides normal operation: with a sample present it
    // becomes the first sample of the new alignment, otherwise we wait for one.
    always_comb begin
        state_next = state;
        take_diff  = 1'b0;
        if (Sync) begin
            state_next = WinValid ? ACCUM : WAIT_FIRST;
        end else if (WinValid) begin
            case (state)
                WAIT_FIRST: state_next = ACCUM;
                ACCUM:      take_diff  = 1'b1;
                default:    state_next = WAIT_FIRST;
            endcase
        end
    end

    // Datapath. Every sample, including the first one after reset or Sync,
    // becomes the reference for the next difference. The last difference of
    // a chip is folded in combinationally so the accumulator can restart at 0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            w_prev     <= '0;
            acc        <= '0;
            sample_cnt <= '0;
            chip_cnt   <= '0;
            Chip       <= 1'b0;
            ChipValid  <= 1'b0;
            ChipWord   <= '0;
            WordValid  <= 1'b0;
        end else begin
            ChipValid <= 1'b0;
            WordValid <= 1'b0;
            if (WinValid) begin
                w_prev <= Win;
            end
            if (Sync) begin
                acc        <= '0;
                sample_cnt <= '0;
                chip_cnt   <= '0;
                ChipWord   <= '0;
            end else if (take_diff) begin
                if (sample_last) begin
                    acc        <= '0;
                    sample_cnt <= '0;
                    Chip       <= chip_bit;
                    ChipValid  <= 1'b1;
                    ChipWord   <= {ChipWord[CHIPS_PER_WORD-2:0], chip_bit};
                    if (word_last) begin
                        WordValid <= 1'b1;
                        chip_cnt  <= '0;
                    end else begin
                        chip_cnt  <= chip_cnt + 1'b1;
                    end
                end else begin
                    acc        <= chip_sum;
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_zigbee_chip_demod.sv
// ---------------------------------------------------------------------------
// tb_zigbee_chip_demod
//
// Directed bench for zigbee_chip_demod with W_SIZE=6, SPC=4 and 32-chip
// words. Each step drives one cycle of inputs and then looks at the
// registered outputs just after the edge that consumed them. Chip and word
// events are tallied per scenario, and the tallies are compared against
// hand-derived values.
// ---------------------------------------------------------------------------
module tb_zigbee_chip_demod;

    logic              Clk;
    logic              Rst;
    logic signed [5:0] Win;
    logic              WinValid;
    logic              Sync;
    logic              Chip;
    logic              ChipValid;
    logic [31:0]       ChipWord;
    logic              WordValid;

    int total;
    int bad;

    int cycle;
    int sample_idx;
    int chip_seen;
    int ones_seen;
    int word_seen;
    logic [31:0] word_val;
    int word_sample;
    int first_chip_sample;
    logic first_chip_val;
    logic [31:0] first_chip_word;
    int last_chip_cycle;
    int spacing;
    int spacing_err;
    int p;

    zigbee_chip_demod #(
        .W_SIZE(6),
        .SPC(4),
        .CHIPS_PER_WORD(32)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Win(Win),
        .WinValid(WinValid),
        .Sync(Sync),
        .Chip(Chip),
        .ChipValid(ChipValid),
        .ChipWord(ChipWord),
        .WordValid(WordValid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Compare one observed value against its expected value.
    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle, then tally the outputs produced by that edge.
    task automatic apply_stimulus(input logic [5:0] win, input logic valid,
                                  input logic sync, input logic rst);
        Win      = win;
        WinValid = valid;
        Sync     = sync;
        Rst      = rst;
        @(posedge Clk);
        #1;
        cycle++;
        if (valid && !rst) sample_idx++;
        if (ChipValid) begin
            if (chip_seen == 0) begin
                first_chip_sample = sample_idx;
                first_chip_val    = Chip;
                first_chip_word   = ChipWord;
            end else if (cycle - last_chip_cycle != spacing) begin
                spacing_err++;
            end
            last_chip_cycle = cycle;
            chip_seen++;
            if (Chip) ones_seen++;
        end
        if (WordValid) begin
            word_seen++;
            word_val    = ChipWord;
            word_sample = sample_idx;
        end
    endtask

    // Start a fresh tally for a new scenario.
    task automatic mark(input int exp_spacing);
        sample_idx        = 0;
        chip_seen         = 0;
        ones_seen         = 0;
        word_seen         = 0;
        word_val          = '0;
        word_sample       = 0;
        first_chip_sample = 0;
        first_chip_val    = 1'b0;
        first_chip_word   = '0;
        last_chip_cycle   = 0;
        spacing_err       = 0;
        spacing           = exp_spacing;
    endtask

    task automatic do_reset();
        apply_stimulus(6'd0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(6'd0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Linear phase ramp; gap idle cycles with junk on Win precede each sample.
    task automatic run_ramp(input int n, input int start, input int step, input int gap);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                apply_stimulus(6'(i * 13 + g * 7 + 5), 1'b0, 1'b0, 1'b0);
            end
            apply_stimulus(6'(start + step * i), 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cycle    = 0;
        Rst      = 1'b1;
        Win      = '0;
        WinValid = 1'b0;
        Sync     = 1'b0;
        mark(4);

        // Reset state
        do_reset();
        check_output("rst_chip",       64'(Chip),      64'd0);
        check_output("rst_chipvalid",  64'(ChipValid), 64'd0);
        check_output("rst_chipword",   64'(ChipWord),  64'd0);
        check_output("rst_wordvalid",  64'(WordValid), 64'd0);

        // Positive ramp, dW = +8, every chip 1
        mark(4);
        run_ramp(129, 0, 8, 0);
        check_output("pos_chips",       64'(chip_seen),         64'd32);
        check_output("pos_ones",        64'(ones_seen),         64'd32);
        check_output("pos_first_chip",  64'(first_chip_sample), 64'd5);
        check_output("pos_words",       64'(word_seen),         64'd1);
        check_output("pos_word_sample", 64'(word_sample),       64'd129);
        check_output("pos_word",        64'(word_val),          64'hFFFFFFFF);
        check_output("pos_spacing",     64'(spacing_err),       64'd0);

        // Constant phase after Sync: zero sum slices to chip 0
        mark(4);
        apply_stimulus(6'd5, 1'b1, 1'b1, 1'b0);
        check_output("zero_sync_chipvalid", 64'(ChipValid), 64'd0);
        check_output("zero_sync_wordvalid", 64'(WordValid), 64'd0);
        for (int i = 0; i < 4; i++) apply_stimulus(6'd5, 1'b1, 1'b0, 1'b0);
        check_output("zero_first_chip", 64'(first_chip_sample), 64'd5);
        check_output("zero_chipvalid",  64'(ChipValid),         64'd1);
        check_output("zero_chip",       64'(Chip),              64'd0);
        check_output("zero_chipword",   64'(ChipWord),          64'd0);

        // Negative ramp across the wrap, dW = -8, every chip 0
        do_reset();
        mark(4);
        run_ramp(129, 0, -8, 0);
        check_output("neg_chips",       64'(chip_seen),   64'd32);
        check_output("neg_ones",        64'(ones_seen),   64'd0);
        check_output("neg_words",       64'(word_seen),   64'd1);
        check_output("neg_word_sample", 64'(word_sample), 64'd129);
        check_output("neg_word",        64'(word_val),    64'h00000000);

        // Alternating chips; first chip contains the 31 -> -29 step (dW = +4)
        do_reset();
        mark(4);
        p = 7;
        apply_stimulus(6'(p), 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 32; c++) begin
            for (int j = 0; j < 4; j++) begin
                if (c == 0 && j == 3) p += 4;
                else if (c % 2 == 0)  p += 8;
                else                  p -= 8;
                apply_stimulus(6'(p), 1'b1, 1'b0, 1'b0);
            end
        end
        check_output("alt_chips",   64'(chip_seen),      64'd32);
        check_output("alt_ones",    64'(ones_seen),      64'd16);
        check_output("alt_first",   64'(first_chip_val), 64'd1);
        check_output("alt_words",   64'(word_seen),      64'd1);
        check_output("alt_word",    64'(word_val),       64'hAAAAAAAA);

        // Positive ramp with a valid sample every third cycle
        do_reset();
        mark(12);
        run_ramp(129, 0, 8, 2);
        check_output("gap_chips",       64'(chip_seen),   64'd32);
        check_output("gap_ones",        64'(ones_seen),   64'd32);
        check_output("gap_spacing",     64'(spacing_err), 64'd0);
        check_output("gap_word_sample", 64'(word_sample), 64'd129);
        check_output("gap_word",        64'(word_val),    64'hFFFFFFFF);

        // Sync with a sample, mid-word and mid-chip (10 chips + 2 differences)
        do_reset();
        mark(4);
        run_ramp(43, 0, 8, 0);
        check_output("sync_pre_chips", 64'(chip_seen), 64'd10);
        mark(4);
        p = 8 * 42 - 2;
        apply_stimulus(6'(p), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            p -= 2;
            apply_stimulus(6'(p), 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 124; i++) begin
            p += 8;
            apply_stimulus(6'(p), 1'b1, 1'b0, 1'b0);
        end
        check_output("sync_first_chip",  64'(first_chip_sample), 64'd5);
        check_output("sync_first_val",   64'(first_chip_val),    64'd0);
        check_output("sync_first_word",  64'(first_chip_word),   64'd0);
        check_output("sync_chips",       64'(chip_seen),         64'd32);
        check_output("sync_words",       64'(word_seen),         64'd1);
        check_output("sync_word_sample", 64'(word_sample),       64'd129);
        check_output("sync_word",        64'(word_val),          64'h7FFFFFFF);

        // Reset right after the 10th chip
        do_reset();
        mark(4);
        run_ramp(41, 0, 8, 0);
        check_output("mrst_pre_chipvalid", 64'(ChipValid), 64'd1);
        check_output("mrst_pre_chipword",  64'(ChipWord),  64'h3FF);
        apply_stimulus(6'h11, 1'b1, 1'b0, 1'b1);
        check_output("mrst_chip",      64'(Chip),      64'd0);
        check_output("mrst_chipvalid", 64'(ChipValid), 64'd0);
        check_output("mrst_chipword",  64'(ChipWord),  64'd0);
        check_output("mrst_wordvalid", 64'(WordValid), 64'd0);
        mark(4);
        run_ramp(129, 24, 8, 0);
        check_output("mrst_words",       64'(word_seen),   64'd1);
        check_output("mrst_word_sample", 64'(word_sample), 64'd129);
        check_output("mrst_word",        64'(word_val),    64'hFFFFFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
